branch_pred_ctrl: RTL and testbench

//  Fetch-stage branch predictor and PC-redirect controller for the 5-stage RV32I pipeline.

---
 rtl/bpu_pkg.sv | 42 ++++
 rtl/branch_pred_ctrl_sat_ctr2.sv | 29 ++
 rtl/branch_pred_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_branch_pred_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bpu_pkg
//  Purpose  : Shared types and constants for the fetch-stage branch predictor.
//             Holds the 2-bit counter encoding, the table entry layout and
//             the controller state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bpu_pkg;

  // Default geometry; the entry struct is laid out with these widths, so the
  // TAG_W / PC_W parameters of branch_pred_ctrl must match them.
  localparam int BPU_ENTRIES = 64;
  localparam int BPU_TAG_W   = 8;
  localparam int BPU_PC_W    = 32;

  // 2-bit saturating direction counter; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Counter value written by the init sweep.
  localparam ctr_t CTR_INIT = WNT;

  typedef struct packed {
    logic                 valid;
    logic [BPU_TAG_W-1:0] tag;
    ctr_t                 ctr;
    logic [BPU_PC_W-1:0]  target;
  } bpu_entry_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : bpu_pkg
`default_nettype wire

// File: rtl/branch_pred_ctrl_sat_ctr2.sv
`default_nettype none
// ============================================================================
//  Module   : sat_ctr2
//  Purpose  : Next-value function of a 2-bit saturating direction counter.
//             Increments toward ST on taken, decrements toward SNT otherwise.
//  Ports    : ctr_in  in  ctr_t  current counter value
//             taken   in  1      resolved direction
//             ctr_out out ctr_t  next counter value
//  Revision : 1.0 - initial release
// ============================================================================
module sat_ctr2
  import bpu_pkg::*;
(
  input  ctr_t ctr_in,
  input  logic taken,
  output ctr_t ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    if (taken) begin
      if (ctr_in != ST) ctr_out = ctr_t'(ctr_in + 2'd1);
    end else begin
      if (ctr_in != SNT) ctr_out = ctr_t'(ctr_in - 2'd1);
    end
  end

endmodule : sat_ctr2
`default_nettype wire

// File: rtl/branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pred_ctrl
//  Purpose  : Fetch-stage branch predictor and PC-redirect controller.
//             Direct-mapped table of {valid, tag, 2-bit ctr, target}, looked
//             up combinationally for the fetch PC, trained from EX, and
//             cleared by a one-entry-per-cycle sweep after reset.
//  Ports    : clk, rst_n                    clock / async active-low reset
//             if_valid, if_pc               fetch lookup request
//             pred_taken, pred_target       prediction for if_pc
//             busy                          init sweep running, stall fetch
//             ex_valid .. ex_pred_target    resolved EX-stage control flow
//             redirect, redirect_pc         mispredict recovery
//             branch_cnt, mispred_cnt       performance counters
//  Revision : 1.0 - initial release
// ============================================================================
module branch_pred_ctrl
  import bpu_pkg::*;
#(
  parameter int ENTRIES = BPU_ENTRIES,
  parameter int TAG_W   = BPU_TAG_W,
  parameter int PC_W    = BPU_PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic            busy,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  // --------------------------------------------------------------------------
  // Controller state and init sweep
  // --------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] sweep_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_idx <= '0;
    end else begin
      state <= state_nxt;
      // Wraps back to 0 as the sweep ends, ready for the next reset.
      if (state == INIT) sweep_idx <= sweep_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      INIT: begin
        busy = 1'b1;
        if (sweep_idx == LAST_IDX) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Table storage (not reset; the sweep clears it)
  // --------------------------------------------------------------------------
  bpu_entry_t bht [ENTRIES];

  // --------------------------------------------------------------------------
  // Fetch lookup
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  bpu_entry_t       if_rd;
  logic             if_hit;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign if_rd  = bht[if_idx];
  // The state term keeps stale, pre-sweep contents from ever predicting.
  assign if_hit = (state == RUN) && if_valid && if_rd.valid && (if_rd.tag == if_tag);

  assign pred_taken  = if_hit && if_rd.ctr[1];
  assign pred_target = pred_taken ? if_rd.target : if_pc + PC_W'(4);

  // --------------------------------------------------------------------------
  // EX resolve and redirect
  // --------------------------------------------------------------------------
  logic            resolve;
  logic            alias_pred;
  logic [PC_W-1:0] ex_seq_pc;
  logic [PC_W-1:0] actual_pc;

  assign resolve    = ex_valid && (ex_is_branch || ex_is_jal);
  // A non-control-flow instruction was predicted taken: a tag alias in the table.
  assign alias_pred = ex_valid && !(ex_is_branch || ex_is_jal) && ex_pred_taken;
  assign ex_seq_pc  = ex_pc + PC_W'(4);
  assign actual_pc  = ex_taken ? ex_target : ex_seq_pc;

  assign redirect    = (resolve && (actual_pc != ex_pred_target)) || alias_pred;
  assign redirect_pc = alias_pred ? ex_seq_pc : actual_pc;

  // --------------------------------------------------------------------------
  // Table training
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  bpu_entry_t       ex_rd;
  logic             ex_hit;
  ctr_t             ctr_next;
  logic             wr_en;
  bpu_entry_t       wr_entry;

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_rd  = bht[ex_idx];
  assign ex_hit = ex_rd.valid && (ex_rd.tag == ex_tag);

  sat_ctr2 u_sat_ctr2 (
    .ctr_in  (ex_rd.ctr),
    .taken   (ex_taken),
    .ctr_out (ctr_next)
  );

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = ex_rd;
    if (state == RUN) begin
      if (resolve) begin
        if (ex_hit) begin
          wr_en        = 1'b1;
          wr_entry.ctr = ctr_next;
          if (ex_taken) wr_entry.target = ex_target;
        end else if (ex_taken) begin
          // JAL is always taken, so it starts out strongly taken.
          wr_en           = 1'b1;
          wr_entry.valid  = 1'b1;
          wr_entry.tag    = ex_tag;
          wr_entry.ctr    = ex_is_jal ? ST : WT;
          wr_entry.target = ex_target;
        end
      end else if (alias_pred && ex_hit) begin
        wr_en          = 1'b1;
        wr_entry.valid = 1'b0;
      end
    end
  end

  // Registered write; a same-cycle lookup of this index still sees the old entry.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      bht[sweep_idx] <= '{valid: 1'b0, tag: '0, ctr: CTR_INIT, target: '0};
    end else if (wr_en) begin
      bht[ex_idx] <= wr_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters (count in any state, wrap naturally)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve)  branch_cnt  <= branch_cnt + 32'd1;
      if (redirect) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule : branch_pred_ctrl
`default_nettype wire

// File: tb/tb_branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_pred_ctrl
//  Purpose  : Self-checking bench for branch_pred_ctrl. A table of one-cycle
//             vectors carries stimulus plus expected outputs; each applied
//             vector is queued and compared when the DUT outputs settle.
//             Hand-written sequences cover the reset sweep and reset in RUN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_pred_ctrl;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            busy;
  logic            ex_valid, ex_is_branch, ex_is_jal, ex_taken, ex_pred_taken;
  logic [PC_W-1:0] ex_pc, ex_target, ex_pred_target;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0]     branch_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_pred_ctrl #(.ENTRIES(64), .TAG_W(8), .PC_W(PC_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .busy           (busy),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  typedef struct {
    logic        if_v;
    logic [31:0] if_a;
    logic        ex_v;
    logic        br;
    logic        jal;
    logic [31:0] ex_a;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_red;
    logic [31:0] e_rpc;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } vec_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t sb[$];
  vec_t vecs[$];

  function automatic vec_t mkv(
    input logic ifv, input logic [31:0] ifa,
    input logic exv, input logic br, input logic jal, input logic [31:0] exa,
    input logic tk, input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
    input logic ept, input logic [31:0] eptgt, input logic ered, input logic [31:0] erpc,
    input logic [31:0] ebc, input logic [31:0] emc);
    vec_t v;
    v.if_v = ifv; v.if_a = ifa; v.ex_v = exv; v.br = br; v.jal = jal; v.ex_a = exa;
    v.tk = tk; v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt;
    v.e_pt = ept; v.e_ptgt = eptgt; v.e_red = ered; v.e_rpc = erpc;
    v.e_bc = ebc; v.e_mc = emc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0; if_pc = '0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_pc = '0;
    ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    if_valid = v.if_v; if_pc = v.if_a;
    ex_valid = v.ex_v; ex_is_branch = v.br; ex_is_jal = v.jal; ex_pc = v.ex_a;
    ex_taken = v.tk; ex_target = v.tgt; ex_pred_taken = v.ptk; ex_pred_target = v.ptgt;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    check($sformatf("v%0d pred_taken", idx), {31'd0, pred_taken}, {31'd0, e.e_pt});
    check($sformatf("v%0d pred_target", idx), pred_target, e.e_ptgt);
    check($sformatf("v%0d redirect", idx), {31'd0, redirect}, {31'd0, e.e_red});
    if (e.e_red) check($sformatf("v%0d redirect_pc", idx), redirect_pc, e.e_rpc);
    check($sformatf("v%0d branch_cnt", idx), branch_cnt, e.e_bc);
    check($sformatf("v%0d mispred_cnt", idx), mispred_cnt, e.e_mc);
  endtask

  // Counts busy cycles from now until busy drops; also watches pred_taken.
  task automatic sweep_check(input string name);
    int busy_cycles = 0;
    int pt_seen     = 0;
    bit done        = 0;
    if_valid = 1'b1; if_pc = 32'h104;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (busy) begin
        busy_cycles++;
        if (pred_taken) pt_seen++;
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL %s busy_timeout: busy still 1 after 200 cycles", name);
    end
    check({name, " busy_cycles"}, busy_cycles, 32'd64);
    check({name, " pred_taken_during_sweep"}, pt_seen, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd1);
    check("reset branch_cnt", branch_cnt, 32'd0);
    check("reset mispred_cnt", mispred_cnt, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sweep_check("init");

    //          ifv   if_pc    exv  br   jal  ex_pc    tk   tgt      ptk  ptgt     ept  eptgt    ered rpc      bcnt mcnt
    vecs.push_back(mkv(1, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h104, 0, 32'h000, 0, 0));
    vecs.push_back(mkv(1, 32'h100, 1, 1, 0, 32'h100, 1, 32'h140, 0, 32'h104, 0, 32'h104, 1, 32'h140, 0, 0));
    vecs.push_back(mkv(1, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 1, 32'h140, 0, 32'h000, 1, 1));
    // same-index lookup and update: lookup sees the old target
    vecs.push_back(mkv(1, 32'h100, 1, 1, 0, 32'h100, 1, 32'h180, 1, 32'h140, 1, 32'h140, 1, 32'h180, 1, 1));
    vecs.push_back(mkv(1, 32'h100, 1, 1, 0, 32'h100, 1, 32'h180, 1, 32'h180, 1, 32'h180, 0, 32'h000, 2, 2));
    vecs.push_back(mkv(1, 32'h100, 1, 1, 0, 32'h100, 1, 32'h180, 1, 32'h180, 1, 32'h180, 0, 32'h000, 3, 2));
    // two not-taken from saturated ST: ST -> WT -> WNT
    vecs.push_back(mkv(1, 32'h100, 1, 1, 0, 32'h100, 0, 32'h180, 1, 32'h180, 1, 32'h180, 1, 32'h104, 4, 2));
    vecs.push_back(mkv(1, 32'h100, 1, 1, 0, 32'h100, 0, 32'h180, 1, 32'h180, 1, 32'h180, 1, 32'h104, 5, 3));
    vecs.push_back(mkv(1, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h104, 0, 32'h000, 6, 4));
    // JAL 0x200 -> 0x080 shares index 0 with 0x100 but has a different tag
    vecs.push_back(mkv(1, 32'h200, 1, 0, 1, 32'h200, 1, 32'h080, 0, 32'h204, 0, 32'h204, 1, 32'h080, 6, 4));
    vecs.push_back(mkv(1, 32'h200, 1, 0, 1, 32'h200, 1, 32'h080, 1, 32'h080, 1, 32'h080, 0, 32'h000, 7, 5));
    vecs.push_back(mkv(1, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h104, 0, 32'h000, 8, 5));
    // alias: non-branch at 0x200 predicted taken -> redirect to 0x204, entry dropped
    vecs.push_back(mkv(1, 32'h200, 1, 0, 0, 32'h200, 0, 32'h000, 1, 32'h080, 1, 32'h080, 1, 32'h204, 8, 5));
    vecs.push_back(mkv(1, 32'h200, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h204, 0, 32'h000, 8, 6));
    // ex_valid=0 with a stale taken prediction: ignored
    vecs.push_back(mkv(0, 32'h300, 0, 1, 0, 32'h100, 1, 32'h140, 1, 32'h140, 0, 32'h304, 0, 32'h000, 8, 6));
    // not-taken miss: counted, but no allocation
    vecs.push_back(mkv(1, 32'h104, 1, 1, 0, 32'h104, 0, 32'h000, 0, 32'h108, 0, 32'h108, 0, 32'h000, 8, 6));
    vecs.push_back(mkv(1, 32'h104, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h108, 0, 32'h000, 9, 6));
    vecs.push_back(mkv(1, 32'h104, 1, 1, 0, 32'h104, 1, 32'h010, 0, 32'h108, 0, 32'h108, 1, 32'h010, 9, 6));
    vecs.push_back(mkv(1, 32'h104, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 1, 32'h010, 0, 32'h000, 10, 7));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset asserted in RUN: back to INIT, counters cleared, table swept.
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    check("rerun busy", {31'd0, busy}, 32'd1);
    check("rerun branch_cnt", branch_cnt, 32'd0);
    check("rerun mispred_cnt", mispred_cnt, 32'd0);
    check("rerun redirect", {31'd0, redirect}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sweep_check("rerun");

    apply(mkv(1, 32'h104, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h108, 0, 32'h000, 0, 0), 100);
    apply(mkv(1, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h104, 0, 32'h000, 0, 0), 101);
    apply(mkv(1, 32'h200, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h204, 0, 32'h000, 0, 0), 102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_branch_pred_ctrl
`default_nettype wire
